zapper_sense: RTL and testbench



---
 rtl/zapper_sense.sv | 155 +++++++++++++++
 tb/tb_zapper_sense.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/zapper_sense.sv
`default_nettype none
// ============================================================================
// Module   : zapper_sense
// Brief    : Light-gun photodiode model that watches the video pixel stream
//            and holds a light flag for a fixed number of scanlines per hit.
// Revision : 1.0  initial release
// ============================================================================
module zapper_sense #(
    parameter int HOLD_LINES = 26,
    parameter int THRESH     = 160,
    parameter int RADIUS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hs,
    input  logic       vs,
    input  logic       de,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic [8:0] gun_x,
    input  logic [8:0] gun_y,
    input  logic       gun_offscreen,
    output logic       light,
    output logic [8:0] x_count,
    output logic [8:0] y_count
);

    localparam int          HOLD_W   = $clog2(HOLD_LINES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_LINES);
    localparam logic [7:0]  THRESH_V = 8'(THRESH);
    localparam logic [9:0]  RADIUS_V = 10'(RADIUS);

    typedef enum logic {
        DARK = 1'b0,
        LIT  = 1'b1
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              light_q;

    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic       de_prev_q, de_prev_d;
    logic       hit_q, hit_d;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;

    logic              hs_rise;
    logic              vs_rise;
    logic [10:0]       luma_sum;
    logic [7:0]        luma;
    logic signed [9:0] dx, dy;
    logic [9:0]        dx_abs, dy_abs;
    logic              inwin;

    assign hs_rise = ce_pix & hs & ~hs_prev_q;
    assign vs_rise = vs & ~vs_prev_q;

    assign luma_sum = {2'b00, r, 1'b0} + ({3'b000, g} * 11'd5) + {3'b000, b};
    assign luma     = luma_sum[10:3];

    // 10-bit signed differences keep columns near 0 and 511 from aliasing.
    assign dx     = $signed({1'b0, x_q}) - $signed({1'b0, gun_x});
    assign dy     = $signed({1'b0, y_q}) - $signed({1'b0, gun_y});
    assign dx_abs = dx[9] ? 10'(-dx) : 10'(dx);
    assign dy_abs = dy[9] ? 10'(-dy) : 10'(dy);
    assign inwin  = (dx_abs <= RADIUS_V) && (dy_abs <= RADIUS_V);

    always_comb begin
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        de_prev_d = de_prev_q;
        x_d       = x_q;
        y_d       = y_q;
        hit_d     = ce_pix & de & ~gun_offscreen & inwin & (luma >= THRESH_V);
        if (ce_pix) begin
            hs_prev_d = hs;
            vs_prev_d = vs;
            de_prev_d = de;
            if (vs_rise) begin
                x_d = '0;
                y_d = '0;
            end else if (de) begin
                x_d = (x_q == 9'd511) ? x_q : x_q + 9'd1;
            end else if (de_prev_q) begin
                x_d = '0;
                y_d = (y_q == 9'd511) ? y_q : y_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            hit_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            de_prev_q <= de_prev_d;
            hit_q     <= hit_d;
            x_q       <= x_d;
            y_q       <= y_d;
        end
    end

    // A fresh hit always reloads the hold, even on a line edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DARK;
            hold_q  <= '0;
            light_q <= 1'b0;
        end else begin
            case (state_q)
                DARK: begin
                    if (hit_q) begin
                        state_q <= LIT;
                        hold_q  <= HOLD_LOAD;
                        light_q <= 1'b1;
                    end
                end
                LIT: begin
                    if (hit_q) begin
                        hold_q <= HOLD_LOAD;
                    end else if (hs_rise) begin
                        if (hold_q == HOLD_W'(1)) begin
                            state_q <= DARK;
                            hold_q  <= '0;
                            light_q <= 1'b0;
                        end else begin
                            hold_q <= hold_q - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= DARK;
                    hold_q  <= '0;
                    light_q <= 1'b0;
                end
            endcase
        end
    end

    assign light   = light_q;
    assign x_count = x_q;
    assign y_count = y_q;

endmodule
`default_nettype wire

// File: tb/tb_zapper_sense.sv
`default_nettype none
// ============================================================================
// Module   : tb_zapper_sense
// Brief    : Self-checking bench for zapper_sense against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_zapper_sense;

    localparam int HOLD = 26;
    localparam int TH   = 160;
    localparam int RAD  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [8:0] gun_x = '0, gun_y = '0;
    logic       gun_offscreen = 1'b0;
    logic       light;
    logic [8:0] x_count, y_count;

    zapper_sense #(.HOLD_LINES(HOLD), .THRESH(TH), .RADIUS(RAD)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
        .r(r), .g(g), .b(b), .gun_x(gun_x), .gun_y(gun_y),
        .gun_offscreen(gun_offscreen), .light(light),
        .x_count(x_count), .y_count(y_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit seen  = 0;

    // Reference model: beam position, pending hit, remaining lines of light.
    int mx = 0, my = 0, mhold = 0;
    bit mhit = 0, mhs = 0, mvs = 0, mde = 0;

    // Scenario knobs used by the frame generator.
    int gx, gy, gy2, gy_sw, off_line, rst_line, px0, py0, px1, py1, lvl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step();
        bit hs_rise;
        int luma;
        if (reset) begin
            mx = 0; my = 0; mhold = 0; mhit = 0; mhs = 0; mvs = 0; mde = 0;
        end else begin
            hs_rise = ce_pix && hs && !mhs;
            if (mhit) mhold = HOLD;
            else if (mhold > 0 && hs_rise) mhold--;
            luma = (2 * int'(r) + 5 * int'(g) + int'(b)) / 8;
            mhit = ce_pix && de && !gun_offscreen && luma >= TH &&
                   iabs(mx - int'(gun_x)) <= RAD && iabs(my - int'(gun_y)) <= RAD;
            if (ce_pix) begin
                if (vs && !mvs) begin
                    mx = 0; my = 0;
                end else if (de) begin
                    mx = (mx < 511) ? mx + 1 : 511;
                end else if (mde) begin
                    mx = 0;
                    my = (my < 511) ? my + 1 : 511;
                end
                mhs = hs; mvs = vs; mde = de;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("light", light, 32'(mhold > 0));
        check("x_count", x_count, mx);
        check("y_count", y_count, my);
        if (light === 1'b1) seen = 1;
    endtask

    task automatic pix(input logic h, input logic v, input logic d,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        hs = h; vs = v; de = d; r = rr; g = gg; b = bb;
        if ($urandom_range(0, 3) == 0) begin
            ce_pix = 1'b0;
            tick();
        end
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
    endtask

    task automatic idle_lines(input int n);
        for (int l = 0; l < n; l++)
            for (int x = 0; x < 16; x++)
                pix(x >= 4 && x < 8, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // mode 0: random colours, 1: uniform grey lvl, 2: white at (px0,py0)/(px1,py1)
    task automatic frame(input int ha, input int va, input int mode);
        logic [7:0] cr, cg, cb;
        logic       d;
        for (int l = 0; l < va + 4; l++) begin
            gun_x = 9'(gx);
            gun_y = 9'((l >= gy_sw) ? gy2 : gy);
            gun_offscreen = (l >= off_line);
            if (l == rst_line) begin
                check("lit_before_rst", light, 1);
                reset = 1'b1; ce_pix = 1'b0;
                tick();
                reset = 1'b0;
                check("rst_light", light, 0);
            end
            for (int x = 0; x < ha + 8; x++) begin
                d = (x < ha) && (l < va);
                cr = 8'd0; cg = 8'd0; cb = 8'd0;
                if (d) begin
                    case (mode)
                        0: begin
                            if ($urandom_range(0, 7) == 0) begin
                                cr = 8'd255; cg = 8'd255; cb = 8'd255;
                            end else begin
                                cr = 8'($urandom_range(0, 255));
                                cg = 8'($urandom_range(0, 255));
                                cb = 8'($urandom_range(0, 255));
                            end
                        end
                        1: begin cr = 8'(lvl); cg = 8'(lvl); cb = 8'(lvl); end
                        default: begin
                            if ((x == px0 && l == py0) || (x == px1 && l == py1)) begin
                                cr = 8'd255; cg = 8'd255; cb = 8'd255;
                            end
                        end
                    endcase
                end
                pix(x >= ha + 2 && x < ha + 5, l == va + 1 || l == va + 2, d, cr, cg, cb);
            end
        end
    endtask

    task automatic setup(input int x, input int y, input int p0x, input int p0y);
        gx = x; gy = y; gy2 = y; gy_sw = 9999; off_line = 9999; rst_line = -1;
        px0 = p0x; py0 = p0y; px1 = -1; py1 = -1;
        idle_lines(30);
        seen = 0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1;
            ce_pix = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            gun_x = 9'($urandom); gun_y = 9'($urandom);
            tick();
        end
        reset = 1'b0; ce_pix = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        tick();
        check("rst_light0", light, 0);
        check("rst_x0", x_count, 0);
        check("rst_y0", y_count, 0);

        setup(100, 50, 100, 50);
        frame(112, 64, 2);
        check("bright_hit", seen, 1);

        setup(10, 10, -1, -1);
        lvl = 100; frame(40, 30, 1); check("dim_100", seen, 0);
        setup(10, 10, -1, -1);
        lvl = 159; frame(40, 30, 1); check("dim_159", seen, 0);
        setup(10, 10, -1, -1);
        lvl = 160; frame(40, 30, 1); check("lit_160", seen, 1);

        setup(10, 10, 13, 10); frame(40, 30, 2); check("win_dx3", seen, 0);
        setup(10, 10, 12, 12); frame(40, 30, 2); check("win_corner", seen, 1);
        setup(10, 10, 8, 8);   frame(40, 30, 2); check("win_neg", seen, 1);
        setup(10, 10, 10, 7);  frame(40, 30, 2); check("win_dym3", seen, 0);
        setup(0, 1, 510, 1);   frame(520, 3, 2); check("no_wrap", seen, 0);

        setup(10, 10, -1, -1);
        off_line = 0; lvl = 255; frame(40, 30, 1); check("offscreen", seen, 0);
        setup(10, 5, 10, 5);
        off_line = 10; frame(40, 30, 2); check("off_mid_hold", seen, 1);

        setup(20, 50, 20, 50);
        px1 = 20; py1 = 60; gy2 = 60; gy_sw = 55;
        frame(112, 64, 2); check("retrigger", seen, 1);

        setup(10, 3, 10, 3);
        rst_line = 8; frame(40, 30, 2);

        setup(1, 300, -1, -1);
        frame(2, 520, 0);

        for (int k = 0; k < 3; k++) begin
            setup($urandom_range(0, 45), $urandom_range(0, 33), -1, -1);
            off_line = $urandom_range(0, 40);
            frame(40, 30, 0);
        end
        idle_lines(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
